// File: rtl/dizy_ctrl_pkg.sv
// Shared types and defaults for the DIZY command/response controller.
package dizy_ctrl_pkg;

  localparam int DIZY_SIZE_STATE = 128;
  localparam int DIZY_SIZE_KEY   = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  typedef enum logic {
    OP_KEY   = 1'b0,
    OP_BLOCK = 1'b1
  } op_e;

endpackage

// File: rtl/dizy_ctrl_outbuf.sv
// Keystream holding register: loads one block, holds it until consumed.
module dizy_ctrl_outbuf #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dizy_ctrl.sv
// DIZY core sequencer: KEY/BLOCK commands in, keystream blocks out.
// Optional per-key block limit: DIZY_CTRL_BLOCK_LIMIT_EN.
module dizy_ctrl
  import dizy_ctrl_pkg::*;
#(
  parameter int SIZE_STATE = DIZY_SIZE_STATE,
  parameter int SIZE_KEY   = DIZY_SIZE_KEY,
  parameter int MAX_BLOCKS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [SIZE_KEY-1:0]   cmd_data,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [SIZE_STATE-1:0] ks_data,
  output logic                  keyed,
  output logic                  err,
  output logic                  core_load,
  output logic                  core_next,
  output logic [SIZE_KEY-1:0]   core_key,
  input  logic                  core_busy,
  input  logic [SIZE_STATE-1:0] core_state
`ifdef DIZY_CTRL_BLOCK_LIMIT_EN
  ,
  output logic [$clog2(MAX_BLOCKS+1)-1:0] blocks_left
`endif
);

  if (MAX_BLOCKS < 1) begin : g_bad_max
    $error("MAX_BLOCKS must be at least 1");
  end

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [SIZE_KEY-1:0] key_q;
  logic                keyed_q, err_q, armed_q;
  logic                accept, reject, start;
  logic                done, cap, limit_hit;

  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign reject    = accept && (cmd_op == OP_BLOCK)
                   && (!keyed_q || limit_hit);
  assign start     = accept && !reject;
  // busy sampled on the first WAIT edge is stale, so wait one edge
  assign done      = (state_q == S_WAIT) && armed_q && !core_busy;
  assign cap       = done && (op_q == OP_BLOCK);

`ifdef DIZY_CTRL_BLOCK_LIMIT_EN
  localparam int            CW   = $clog2(MAX_BLOCKS+1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BLOCKS);

  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == MAXC);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      if (cmd_op == OP_KEY) cnt_d = '0;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign blocks_left = keyed_q ? (MAXC - cnt_q) : '0;
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_KEY;
      key_q   <= '0;
      keyed_q <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      armed_q <= (state_q == S_WAIT);
      if (start) begin
        key_q <= cmd_data;
        op_q  <= op_e'(cmd_op);
      end
      if (done && (op_q == OP_KEY)) keyed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PULSE;
      S_PULSE: if (!core_busy) state_d = S_WAIT;
      S_WAIT:  if (done) begin
        state_d = (op_q == OP_BLOCK) ? S_OUT : S_IDLE;
      end
      S_OUT:   if (ks_valid && ks_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // a restart is held off while a pre-reset run is still busy
  always_comb begin
    core_load = 1'b0;
    core_next = 1'b0;
    if ((state_q == S_PULSE) && !core_busy) begin
      core_load = (op_q == OP_KEY);
      core_next = (op_q == OP_BLOCK);
    end
  end

  assign core_key = key_q;
  assign keyed    = keyed_q;
  assign err      = err_q;

  dizy_ctrl_outbuf #(
    .W(SIZE_STATE)
  ) u_outbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cap),
    .data_i (core_state),
    .ready_i(ks_ready),
    .valid_o(ks_valid),
    .data_o (ks_data)
  );

endmodule
